// File: rtl/fetch_ctrl.sv
// Fetch/decode sequencer: drives memory reads, IR load and PC increment, hands decoded
// instructions to the execution unit, and tracks HALT, fetch timeouts and retirements.
module fetch_ctrl #(
  parameter int               OPC_W    = 4,
  parameter logic [OPC_W-1:0] HALT_OPC = 4'hF,
  parameter int               TIMEOUT  = 15,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             mem_ack,
  input  logic [OPC_W-1:0] opcode,
  input  logic             exec_done,
  output logic             mem_rd,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             exec_start,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t           state_q;
  logic [TMR_W-1:0] timer;

  // Handshakes: mem_rd is held for the whole FETCH state and a read completes on the
  // first cycle mem_ack is seen there; exec_start is a one-cycle pulse and the EU
  // answers with a one-cycle exec_done, accepted only while in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer     <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_q != S_FETCH) timer <= '0;
      case (state_q)
        S_IDLE: begin
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ack)                       state_q <= S_LOAD;
          else if (timer == TMR_W'(TIMEOUT)) state_q <= S_FAULT;
          else                               timer   <= timer + 1'b1;
        end
        S_LOAD: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode == HALT_OPC) begin
            state_q   <= S_HALT;
            instr_cnt <= instr_cnt + 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            instr_cnt <= instr_cnt + 1'b1;
            state_q   <= run ? S_FETCH : S_IDLE;
          end
        end
        S_HALT:  state_q <= S_HALT;
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode straight off the state register so reset clears them asynchronously.
  assign mem_rd     = (state_q == S_FETCH);
  assign ir_ld      = (state_q == S_LOAD);
  assign pc_inc     = (state_q == S_LOAD);
  assign exec_start = (state_q == S_DECODE) && (opcode != HALT_OPC);
  assign halted     = (state_q == S_HALT);
  assign fault      = (state_q == S_FAULT);
  assign state      = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: instruction loop, timeout, HALT, run drop, counter wrap
// and asynchronous reset, with retirement counts checked through an expected queue.
module tb_fetch_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             mem_ack;
  logic [3:0]       opcode;
  logic             exec_done;
  logic             mem_rd, ir_ld, pc_inc, exec_start, halted, fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] model_cnt;
  int               n_tests = 0;
  int               n_fail  = 0;

  fetch_ctrl #(.OPC_W(4), .HALT_OPC(4'hF), .TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mem_ack    (mem_ack),
    .opcode     (opcode),
    .exec_done  (exec_done),
    .mem_rd     (mem_rd),
    .ir_ld      (ir_ld),
    .pc_inc     (pc_inc),
    .exec_start (exec_start),
    .halted     (halted),
    .fault      (fault),
    .state      (state),
    .instr_cnt  (instr_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // all Moore outputs packed as {mem_rd, ir_ld, pc_inc, exec_start, halted, fault}
  task automatic chk_outs(input string tag, input logic [2:0] st, input logic [5:0] outs);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_outs"}, 32'({mem_rd, ir_ld, pc_inc, exec_start, halted, fault}), 32'(outs));
  endtask

  // scoreboard
  task automatic push_retire();
    model_cnt = model_cnt + 1'b1;
    exp_q.push_back(model_cnt);
  endtask

  task automatic sb_check(input string tag);
    logic [CNT_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed %0h expected queue empty", tag, instr_cnt);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(instr_cnt), 32'(e));
    end
  endtask

  // drivers
  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0; opcode = 4'h0;
    cyc();
    chk_outs("reset", 3'd0, 6'b000000);
    chk("reset_cnt", 32'(instr_cnt), 32'd0);
    rst = 1'b0;
    model_cnt = '0;
    exp_q.delete();
  endtask

  // starts in FETCH; ack, decode, done on first EXEC cycle
  task automatic run_instr(input logic [3:0] opc, input string tag);
    opcode = opc; mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0;
    chk_outs({tag, "_load"}, 3'd2, 6'b011000);
    cyc();
    chk_outs({tag, "_decode"}, 3'd3, 6'b000100);
    cyc(); exec_done = 1'b1; push_retire();
    cyc(); exec_done = 1'b0;
    sb_check({tag, "_cnt"});
  endtask

  initial begin
    do_reset();

    // 1: basic loop with ack and done in their first cycles
    run = 1'b1; opcode = 4'h1;
    cyc();
    chk_outs("t1_fetch", 3'd1, 6'b100000);
    mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0;
    chk_outs("t1_load", 3'd2, 6'b011000);
    cyc();
    chk_outs("t1_decode", 3'd3, 6'b000100);
    cyc();
    chk_outs("t1_exec", 3'd4, 6'b000000);
    exec_done = 1'b1; push_retire();
    cyc(); exec_done = 1'b0;
    chk_outs("t1_refetch", 3'd1, 6'b100000);
    sb_check("t1_cnt");

    // 4: run dropped mid-instruction finishes it, then idles
    run = 1'b0;
    run_instr(4'h2, "t4");
    chk_outs("t4_idle", 3'd0, 6'b000000);
    cyc(); cyc();
    chk_outs("t4_stay_idle", 3'd0, 6'b000000);

    // 6b: stray ack/done in IDLE are ignored
    mem_ack = 1'b1; exec_done = 1'b1;
    cyc(); mem_ack = 1'b0; exec_done = 1'b0;
    chk_outs("t6_stray", 3'd0, 6'b000000);
    chk("t6_stray_cnt", 32'(instr_cnt), 32'(model_cnt));

    // 2a: no ack for 16 FETCH cycles -> fault
    run = 1'b1;
    cyc();
    for (int i = 1; i <= 15; i++) cyc();
    chk_outs("t2_fetch_last", 3'd1, 6'b100000);
    cyc();
    chk_outs("t2_fault", 3'd6, 6'b000001);
    mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0;
    chk_outs("t2_fault_sticky", 3'd6, 6'b000001);
    do_reset();

    // 2b: ack on the last allowed FETCH cycle wins over timeout
    run = 1'b1;
    cyc();
    for (int i = 1; i <= 15; i++) cyc();
    run_instr(4'h3, "t2b");
    chk("t2b_no_fault", 32'(fault), 32'd0);

    // 5: wrap the 4-bit counter, with one exec_done arriving during DECODE
    opcode = 4'h5; mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0;
    cyc(); exec_done = 1'b1;
    cyc(); exec_done = 1'b0;
    chk_outs("t5_early_done", 3'd4, 6'b000000);
    chk("t5_early_cnt", 32'(instr_cnt), 32'(model_cnt));
    exec_done = 1'b1; push_retire();
    cyc(); exec_done = 1'b0;
    sb_check("t5_late_cnt");
    for (int i = 0; i < 14; i++) run_instr(4'($urandom_range(0, 14)), "t5_loop");
    chk("t5_wrapped", 32'(instr_cnt), 32'd0);

    // 3: HALT retires and then ignores everything
    opcode = 4'hF; mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0;
    cyc();
    chk_outs("t3_decode", 3'd3, 6'b000000);
    push_retire();
    cyc();
    chk_outs("t3_halt", 3'd5, 6'b000010);
    sb_check("t3_cnt");
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      mem_ack = 1'($urandom_range(0, 1));
      exec_done = 1'($urandom_range(0, 1));
      opcode = 4'($urandom_range(0, 15));
      cyc();
    end
    chk_outs("t3_halt_sticky", 3'd5, 6'b000010);
    chk("t3_cnt_frozen", 32'(instr_cnt), 32'(model_cnt));
    do_reset();

    // 6a: asynchronous reset mid-FETCH and mid-EXEC
    run = 1'b1; opcode = 4'h1;
    cyc();
    #2 rst = 1'b1;
    #1 chk_outs("t6_rst_fetch", 3'd0, 6'b000000);
    cyc(); rst = 1'b0;
    cyc(); mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0;
    cyc(); cyc();
    chk_outs("t6_exec", 3'd4, 6'b000000);
    #2 rst = 1'b1;
    #1 chk_outs("t6_rst_exec", 3'd0, 6'b000000);
    chk("t6_rst_cnt", 32'(instr_cnt), 32'd0);
    cyc(); rst = 1'b0; run = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
